core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Single-port memory arbiter sharing the core's one external bus between the instruction prefetch buffer and the load/store unit. It holds at most one outstanding bus transaction and picks requesters round-robin when both are pending. Fetch responses are returned as the prefetch buffer's `fetched`/`fetch_data` pair, and a pipeline flush discards any fetch response still in flight.

## Interface
- No parameters. `word` (32-bit) and `ptr` (30-bit word address) come from `core/uarch.sv`.
- `clk  in  1`: the only clock. All state changes on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `fetch  in  1`: prefetch buffer wants one word. Held as a level.
- `fetch_addr  in  ptr`: word address to fetch. Sampled at grant.
- `flush  in  1`: pipeline flush. Kills the pending or in-flight fetch response.
- `fetched  out  1`: one-cycle pulse; `fetch_data` is valid in that cycle.
- `fetch_data  out  word`: fetched instruction word.
- `data_start  in  1`: LSU request. Held as a level until `data_ready`.
- `data_write  in  1`: 1 means store, 0 means load.
- `data_addr  in  ptr`: LSU word address. Sampled at grant.
- `data_wr  in  word`: store data. Sampled at grant.
- `data_be  in  4`: byte enables. Sampled at grant.
- `data_ready  out  1`: one-cycle pulse; the LSU transaction is complete.
- `data_rd  out  word`: load data, valid while `data_ready` is high.
- `bus_start  out  1`: one-cycle pulse that opens a bus transaction.
- `bus_write  out  1`: write strobe for the current transaction.
- `bus_addr  out  ptr`: transaction address.
- `bus_data_wr  out  word`: transaction write data.
- `bus_be  out  4`: transaction byte enables.
- `bus_ready  in  1`: slave completion strobe. `bus_data_rd` is valid while it is high.
- `bus_data_rd  in  word`: slave read data.

## Operation
- FSM states: IDLE, FETCH, DATA. Auxiliary registers:
  - `drop`: discard the current fetch response.
  - `last`: last grantee, 0 = fetch, 1 = data.
- IDLE, evaluated combinationally each cycle:
  - `want_f` = `fetch & ~flush`; `want_d` = `data_start`.
  - Only one pending: grant it.
  - Both pending: grant the requester that was not granted last. Then `last` is updated.
- Grant to fetch:
  - Next state FETCH.
  - `bus_addr` is loaded from `fetch_addr`; `bus_write` = 0; `bus_be` = 4'hF.
  - `drop` is cleared.
- Grant to data:
  - Next state DATA.
  - `bus_addr`, `bus_write`, `bus_data_wr` and `bus_be` are loaded from the `data_*` inputs.
- `bus_start` is high for exactly the first cycle of FETCH or DATA.
- All `bus_*` outputs hold stable until the cycle after `bus_ready`.
- FETCH:
  - `flush` in any cycle, including the `bus_ready` cycle, sets `drop`.
  - On `bus_ready`, the next state is IDLE.
  - `fetched` pulses next cycle only if `drop` is clear and `flush` is low in the `bus_ready` cycle.
  - `fetch_data` is registered from `bus_data_rd`.
- DATA:
  - On `bus_ready`, the next state is IDLE.
  - `data_ready` pulses next cycle with `data_rd` registered from `bus_data_rd`.
  - `flush` has no effect on data transactions. Stores already on the bus always complete.
- `bus_ready` is ignored in IDLE and in the `bus_start` cycle. A slave completes no earlier than one cycle after `bus_start`.
- `fetched` and `data_ready` are never high in the same cycle.
- `fetch_data` and `data_rd` hold their values between pulses.

## Timing
- Reset, asynchronous on `rst_n` low:
  - State is IDLE; `drop` = 0; `last` = 1, so fetch wins the first tie.
  - All outputs are 0.
- Reset while a transaction is in flight: abandoned immediately. No response pulse is produced, and a later `bus_ready` in IDLE is ignored.
- Grant latency: a request seen in IDLE at cycle N gives `bus_start` at N+1.
- Response latency: `bus_ready` at cycle M gives `fetched` or `data_ready` at M+1. The state is IDLE at M+1.
- Throughput: the earliest next `bus_start` is M+2, because the FSM spends one IDLE cycle. Peak rate is one transaction per 3 cycles with a 1-cycle slave.
- `flush` high in IDLE with `fetch` high: no fetch grant that cycle. A pending `data_start` may still be granted.
- `flush` in the same cycle that `fetched` is high: `fetched` is not masked (already registered). The consumer gives flush priority.

## Test plan
- Single fetch, slave ready 1 cycle after start:
  - Stimulus: `fetch`=1 with addr 0x100 at cycle 0.
  - Required: `bus_start`=1 with `bus_addr`=0x100 and `bus_write`=0 at cycle 1; `bus_ready` at 2; `fetched`=1 with `fetch_data`=0xE1A00000 at 3, exactly one pulse.
- Round-robin:
  - Stimulus: `fetch` and `data_start` both held high from reset.
  - Required: grants alternate fetch, data, fetch, data. Each `data_ready` pulse coincides with the LSU dropping its request. No requester is starved over 8 transactions.
- Flush mid-fetch:
  - Stimulus: fetch granted, slave delays `bus_ready` 5 cycles, `flush` pulsed in wait cycle 2.
  - Required: no `fetched` pulse; FSM returns to IDLE; the next fetch (addr 0x200) returns normally.
- Flush in the `bus_ready` cycle: required no `fetched`. Flush during a store: the store completes and `data_ready` pulses.
- Store:
  - Stimulus: `data_write`=1, addr 0x3FF, `data_wr`=0xDEADBEEF, be=4'b0011.
  - Required: bus fields match and hold stable until `bus_ready`; `data_ready` pulses once.
- Async reset:
  - Stimulus: `rst_n` low in the middle of a DATA transaction.
  - Required: all outputs 0 immediately. A stray `bus_ready` after reset produces no pulse. The first tie after reset grants fetch.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// Signal bundle between the core requesters (prefetch, LSU), the arbiter and the memory bus.
// Handshakes: fetch/data_start are request levels held until answered by a one-cycle
// fetched/data_ready pulse; bus_start is a one-cycle open strobe and bus_ready is the slave's
// one-cycle completion strobe, with bus_data_rd valid only while bus_ready is high.
interface core_mem_arbiter_if;
  logic        fetch;
  logic [29:0] fetch_addr;
  logic        flush;
  logic        fetched;
  logic [31:0] fetch_data;

  logic        data_start;
  logic        data_write;
  logic [29:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_be;
  logic        data_ready;
  logic [31:0] data_rd;

  logic        bus_start;
  logic        bus_write;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_data_rd;

  modport master (
    input  fetch, fetch_addr, flush,
           data_start, data_write, data_addr, data_wr, data_be,
           bus_ready, bus_data_rd,
    output fetched, fetch_data, data_ready, data_rd,
           bus_start, bus_write, bus_addr, bus_data_wr, bus_be
  );

  modport slave (
    output fetch, fetch_addr, flush,
           data_start, data_write, data_addr, data_wr, data_be,
           bus_ready, bus_data_rd,
    input  fetched, fetch_data, data_ready, data_rd,
           bus_start, bus_write, bus_addr, bus_data_wr, bus_be
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares the single external bus between instruction prefetch and the LSU, one
// outstanding transaction at a time, round-robin on ties; flush discards fetch responses.
module core_mem_arbiter (
  input  logic                      clk,
  input  logic                      rst_n,
  core_mem_arbiter_if.master        mif,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic        last_q, last_d;
  logic        start_q, start_d;
  logic        write_q, write_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        fetched_q, fetched_d;
  logic [31:0] fdata_q, fdata_d;
  logic        dready_q, dready_d;
  logic [31:0] rdata_q, rdata_d;

  logic want_f, want_d, done;

  assign want_f = mif.fetch & ~mif.flush;
  assign want_d = mif.data_start;
  // The slave cannot complete in the bus_start cycle, so a strobe there is stray.
  assign done   = mif.bus_ready & ~start_q;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    last_d    = last_q;
    start_d   = 1'b0;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    fetched_d = 1'b0;
    fdata_d   = fdata_q;
    dready_d  = 1'b0;
    rdata_d   = rdata_q;

    unique case (state_q)
      IDLE: begin
        // last_q = 1 means data was served last, so fetch wins a tie.
        if (want_f && (!want_d || last_q)) begin
          state_d = FETCH;
          start_d = 1'b1;
          addr_d  = mif.fetch_addr;
          write_d = 1'b0;
          be_d    = 4'hF;
          drop_d  = 1'b0;
          last_d  = 1'b0;
        end else if (want_d) begin
          state_d = DATA;
          start_d = 1'b1;
          addr_d  = mif.data_addr;
          write_d = mif.data_write;
          wdata_d = mif.data_wr;
          be_d    = mif.data_be;
          last_d  = 1'b1;
        end
      end

      FETCH: begin
        if (mif.flush) drop_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          if (!drop_q && !mif.flush) begin
            fetched_d = 1'b1;
            fdata_d   = mif.bus_data_rd;
          end
        end
      end

      DATA: begin
        if (done) begin
          state_d  = IDLE;
          dready_d = 1'b1;
          rdata_d  = mif.bus_data_rd;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      last_q    <= 1'b1;
      start_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      fetched_q <= 1'b0;
      fdata_q   <= '0;
      dready_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      last_q    <= last_d;
      start_q   <= start_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      fetched_q <= fetched_d;
      fdata_q   <= fdata_d;
      dready_q  <= dready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mif.bus_start   = start_q;
  assign mif.bus_write   = write_q;
  assign mif.bus_addr    = addr_q;
  assign mif.bus_data_wr = wdata_q;
  assign mif.bus_be      = be_q;
  assign mif.fetched     = fetched_q;
  assign mif.fetch_data  = fdata_q;
  assign mif.data_ready  = dready_q;
  assign mif.data_rd     = rdata_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  core_mem_arbiter_if mif();

  core_mem_arbiter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mif         (mif),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model configuration ----------------
  int          sl_delay = 1;   // 0 selects a random 1..4 cycle delay
  bit          sl_stray = 1'b0;
  bit          sl_fixed = 1'b0;
  logic [31:0] sl_rdata = 32'h0;

  initial begin
    int cnt;
    bit active;
    cnt = 0;
    active = 1'b0;
    mif.bus_ready   = 1'b0;
    mif.bus_data_rd = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mif.bus_ready = 1'b0;
      if (mif.bus_start) begin
        active = 1'b1;
        cnt = (sl_delay > 0) ? sl_delay : int'($urandom_range(1, 4));
        if (sl_stray && $urandom_range(0, 3) == 0) begin
          mif.bus_ready   = 1'b1;
          mif.bus_data_rd = $urandom;
        end
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          active          = 1'b0;
          mif.bus_ready   = 1'b1;
          mif.bus_data_rd = sl_fixed ? sl_rdata : $urandom;
        end
      end else if (sl_stray && $urandom_range(0, 5) == 0) begin
        mif.bus_ready   = 1'b1;
        mif.bus_data_rd = $urandom;
      end
    end
  end

  // ---------------- reference model (one transaction record) ----------------
  logic        m_busy, m_first, m_kill, m_is_data, m_last_data;
  logic        m_start, m_fetched, m_dready, m_write;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_fdata, m_rdata;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_kill = 0; m_is_data = 0; m_last_data = 1;
    m_start = 0; m_fetched = 0; m_dready = 0; m_write = 0;
    m_addr = '0; m_wdata = '0; m_fdata = '0; m_rdata = '0; m_be = '0;
  endtask

  // Called at each rising edge with the inputs as they stood during the ending cycle;
  // leaves the outputs expected for the cycle that begins.
  task automatic model_step();
    logic wf, wd, pick_d;
    m_start = 0; m_fetched = 0; m_dready = 0;
    if (m_busy) begin
      if (!m_is_data && mif.flush) m_kill = 1;
      if (mif.bus_ready && !m_first) begin
        m_busy = 0;
        if (m_is_data) begin
          m_dready = 1;
          m_rdata  = mif.bus_data_rd;
        end else if (!m_kill) begin
          m_fetched = 1;
          m_fdata   = mif.bus_data_rd;
        end
      end
      m_first = 0;
    end else begin
      wf = mif.fetch && !mif.flush;
      wd = mif.data_start;
      if (wf || wd) begin
        pick_d      = wd && (!wf || !m_last_data);
        m_busy      = 1;
        m_first     = 1;
        m_start     = 1;
        m_kill      = 0;
        m_is_data   = pick_d;
        m_last_data = pick_d;
        if (pick_d) begin
          m_addr  = mif.data_addr;
          m_write = mif.data_write;
          m_wdata = mif.data_wr;
          m_be    = mif.data_be;
        end else begin
          m_addr  = mif.fetch_addr;
          m_write = 0;
          m_be    = 4'hF;
        end
      end
    end
  endtask

  // ---------------- scoreboard compare process ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("bus_start",   32'(mif.bus_start),   32'(m_start));
    check("bus_write",   32'(mif.bus_write),   32'(m_write));
    check("bus_addr",    32'(mif.bus_addr),    32'(m_addr));
    check("bus_data_wr", mif.bus_data_wr,      m_wdata);
    check("bus_be",      32'(mif.bus_be),      32'(m_be));
    check("fetched",     32'(mif.fetched),     32'(m_fetched));
    check("fetch_data",  mif.fetch_data,       m_fdata);
    check("data_ready",  32'(mif.data_ready),  32'(m_dready));
    check("data_rd",     mif.data_rd,          m_rdata);
    check("resp_excl",   32'(mif.fetched & mif.data_ready), 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drain();
    mif.fetch = 0; mif.data_start = 0; mif.flush = 0;
    repeat (10) tick();
  endtask

  task automatic wait_start(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mif.bus_start) begin
        ok = 1;
        break;
      end
    end
    check({name, "_start_seen"}, 32'(ok), 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic [31:0] glog[$];

    mif.fetch = 0; mif.fetch_addr = '0; mif.flush = 0;
    mif.data_start = 0; mif.data_write = 0; mif.data_addr = '0;
    mif.data_wr = '0; mif.data_be = '0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("rst_bus_start",  32'(mif.bus_start),  32'h0);
    check("rst_fetched",    32'(mif.fetched),    32'h0);
    check("rst_data_ready", 32'(mif.data_ready), 32'h0);
    check("rst_bus_be",     32'(mif.bus_be),     32'h0);
    repeat (2) tick();
    rst_n = 1;

    // Single fetch with a one-cycle slave.
    sl_delay = 1; sl_fixed = 1; sl_rdata = 32'hE1A00000;
    mif.fetch = 1; mif.fetch_addr = 30'h100;
    tick();
    check("t1_bus_start", 32'(mif.bus_start), 32'h1);
    check("t1_bus_addr",  32'(mif.bus_addr),  32'h100);
    check("t1_bus_write", 32'(mif.bus_write), 32'h0);
    check("t1_bus_be",    32'(mif.bus_be),    32'hF);
    mif.fetch = 0;
    tick();
    tick();
    check("t1_fetched",    32'(mif.fetched), 32'h1);
    check("t1_fetch_data", mif.fetch_data,   32'hE1A00000);
    tick();
    check("t1_one_pulse",  32'(mif.fetched), 32'h0);
    drain();

    // Round-robin with both requesters held from reset.
    sl_fixed = 0; sl_delay = 0;
    do_reset();
    mif.fetch = 1; mif.fetch_addr = 30'h400;
    mif.data_start = 1; mif.data_write = 1; mif.data_addr = 30'h2000;
    mif.data_wr = 32'h11110000; mif.data_be = 4'hF;
    glog.delete();
    for (int c = 0; c < 80 && glog.size() < 8; c++) begin
      tick();
      if (mif.bus_start) glog.push_back(32'(mif.bus_write));
      if (mif.data_ready) mif.data_start = 0;
      else if (!mif.data_start) begin
        mif.data_start = 1;
        mif.data_addr  = 30'h2000 + 30'(c);
        mif.data_wr    = 32'h11110000 + 32'(c);
      end
    end
    check("rr_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < glog.size(); i++) check("rr_order", glog[i], 32'(i % 2));
    drain();

    // Flush in the middle of a slow fetch, then a normal fetch.
    sl_delay = 5;
    mif.fetch = 1; mif.fetch_addr = 30'h180;
    wait_start(10, "fl_mid");
    mif.fetch = 0;
    tick();
    tick();
    mif.flush = 1;
    tick();
    mif.flush = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (mif.fetched) pulses++;
      tick();
    end
    check("fl_mid_no_fetched", 32'(pulses), 32'h0);
    check("fl_mid_idle", 32'(dbg_state), 32'h0);
    sl_delay = 1; sl_fixed = 1; sl_rdata = 32'hCAFE0200;
    mif.fetch = 1; mif.fetch_addr = 30'h200;
    wait_start(10, "fl_next");
    check("fl_next_addr", 32'(mif.bus_addr), 32'h200);
    mif.fetch = 0;
    pulses = 0;
    for (int c = 0; c < 6 && pulses == 0; c++) begin
      tick();
      if (mif.fetched) begin
        pulses++;
        check("fl_next_data", mif.fetch_data, 32'hCAFE0200);
      end
    end
    check("fl_next_pulse", 32'(pulses), 32'h1);
    drain();

    // Flush in the bus_ready cycle.
    sl_delay = 2;
    mif.fetch = 1; mif.fetch_addr = 30'h210;
    wait_start(10, "fl_rdy");
    mif.fetch = 0;
    tick();
    tick();
    mif.flush = 1;
    tick();
    mif.flush = 0;
    check("fl_rdy_no_fetched", 32'(mif.fetched), 32'h0);
    tick();
    check("fl_rdy_no_fetched2", 32'(mif.fetched), 32'h0);
    drain();

    // Store with flush held throughout: fields stable, completes once.
    sl_delay = 3; sl_fixed = 0;
    mif.flush = 1;
    mif.data_start = 1; mif.data_write = 1; mif.data_addr = 30'h3FF;
    mif.data_wr = 32'hDEADBEEF; mif.data_be = 4'b0011;
    wait_start(10, "st");
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      check("st_write", 32'(mif.bus_write),   32'h1);
      check("st_addr",  32'(mif.bus_addr),    32'h3FF);
      check("st_wdata", mif.bus_data_wr,      32'hDEADBEEF);
      check("st_be",    32'(mif.bus_be),      32'h3);
      tick();
      if (mif.data_ready) begin
        pulses++;
        mif.data_start = 0;
      end
    end
    check("st_pulses", 32'(pulses), 32'h1);
    drain();

    // Asynchronous reset in the middle of a load.
    sl_delay = 4;
    mif.data_start = 1; mif.data_write = 0; mif.data_addr = 30'h55; mif.data_be = 4'hF;
    wait_start(10, "ar");
    tick();
    rst_n = 0;
    #1;
    check("ar_bus_start",  32'(mif.bus_start),  32'h0);
    check("ar_bus_addr",   32'(mif.bus_addr),   32'h0);
    check("ar_bus_be",     32'(mif.bus_be),     32'h0);
    check("ar_data_ready", 32'(mif.data_ready), 32'h0);
    check("ar_data_rd",    mif.data_rd,         32'h0);
    check("ar_fetch_data", mif.fetch_data,      32'h0);
    mif.data_start = 0;
    tick();
    tick();
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mif.data_ready || mif.fetched) pulses++;
    end
    check("ar_stray_ignored", 32'(pulses), 32'h0);
    mif.fetch = 1; mif.fetch_addr = 30'h77;
    mif.data_start = 1; mif.data_addr = 30'h88;
    wait_start(10, "ar_tie");
    check("ar_tie_write", 32'(mif.bus_write), 32'h0);
    check("ar_tie_addr",  32'(mif.bus_addr),  32'h77);
    drain();

    // Random traffic with stray slave strobes and random flushes.
    sl_delay = 0; sl_stray = 1; sl_fixed = 0;
    for (int c = 0; c < 1500; c++) begin
      if (mif.data_ready) mif.data_start = 0;
      else if (!mif.data_start && $urandom_range(0, 3) == 0) begin
        mif.data_start = 1;
        mif.data_write = 1'($urandom_range(0, 1));
        mif.data_addr  = 30'($urandom);
        mif.data_wr    = $urandom;
        mif.data_be    = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        mif.fetch      = 1'($urandom_range(0, 1));
        mif.fetch_addr = 30'($urandom);
      end
      mif.flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    sl_stray = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
